// File: rtl/axilite_pkg.sv
// axilite_pkg: shared widths, FSM states and response codes for the AXI-Lite master arbiter
package axilite_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_RESP = 2'd2} state_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b11;
endpackage

// File: rtl/axilite_rr_pick.sv
// axilite_rr_pick: first set request searching upward from last_grant+1, wrapping modulo N
module axilite_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] grant,
  output logic          any
);
  logic [IW-1:0] idx;
  always_comb begin
    grant = last_grant;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (req[idx]) grant = idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/axilite_m_arbiter.sv
// axilite_m_arbiter: round-robin arbiter serialising requester commands onto one AXI-Lite master user port
module axilite_m_arbiter
  import axilite_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      stuck,
  output logic                      write,
  output logic                      read,
  output logic [ADDR_W-1:0]         user_waddr,
  output logic [ADDR_W-1:0]         user_raddr,
  output logic [DATA_W-1:0]         user_wdata,
  input  logic [DATA_W-1:0]         user_rdata,
  input  logic                      wr_ready,
  input  logic                      rd_ready,
  input  logic                      wr_error,
  input  logic                      rd_error
);
  state_e state, state_d;
  logic [IW-1:0] last_grant, pick;
  logic any, we_q, take, done;
  logic [1:0] code;
  logic [CW-1:0] cnt;

  axilite_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .last_grant(last_grant),
    .grant(pick),
    .any(any)
  );

  // completion of the opposite transfer type is ignored while waiting
  always_comb begin
    take = state == ST_IDLE && any;
    done = state == ST_WAIT && (we_q ? wr_ready : rd_ready);
    code = (we_q ? wr_error : rd_error) ? RESP_ERR : RESP_OKAY;
    state_d = take ? ST_WAIT : done ? ST_RESP : state == ST_RESP ? ST_IDLE : state;
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn)
    if (!m_axi_aresetn) state <= ST_IDLE;
    else state <= state_d;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      we_q       <= 1'b0;
      write      <= 1'b0;
      read       <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      stuck      <= 1'b0;
      cnt        <= '0;
      user_waddr <= '0;
      user_raddr <= '0;
      user_wdata <= '0;
    end else begin
      write      <= 1'b0;
      read       <= 1'b0;
      req_ready  <= '0;
      resp_valid <= '0;
      if (take) begin
        grant_id  <= pick;
        we_q      <= req_we[pick];
        write     <= req_we[pick];
        read      <= !req_we[pick];
        req_ready <= NUM_REQ'(1) << pick;
        busy      <= 1'b1;
        cnt       <= '0;
        if (req_we[pick]) begin
          user_waddr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
          user_wdata <= req_wdata[int'(pick)*DATA_W +: DATA_W];
        end else user_raddr <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
      end
      // the counter saturates; stuck is sticky and the wait continues
      if (state == ST_WAIT && !done) begin
        if (cnt != CW'(TIMEOUT_CYC)) cnt <= cnt + 1'b1;
        if (cnt == CW'(TIMEOUT_CYC - 1)) stuck <= 1'b1;
      end
      if (done) begin
        resp_err   <= code != RESP_OKAY;
        resp_rdata <= we_q ? '0 : user_rdata;
        resp_valid <= NUM_REQ'(1) << grant_id;
      end
      if (state == ST_RESP) begin
        last_grant <= grant_id;
        busy       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axilite_m_arbiter.sv
// tb_axilite_m_arbiter: randomized scoreboard bench with a transaction-level arbiter/memory model
module tb_axilite_m_arbiter;
  localparam int N = 4, AW = 32, DW = 32, TO = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid = '0, req_we = '0, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0] resp_rdata, user_wdata, user_rdata;
  logic [AW-1:0] user_waddr, user_raddr;
  logic [1:0] grant_id;
  logic resp_err, busy, stuck, write, read;
  logic wr_ready, rd_ready, wr_error, rd_error;

  axilite_m_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .grant_id(grant_id), .stuck(stuck), .write(write), .read(read),
    .user_waddr(user_waddr), .user_raddr(user_raddr), .user_wdata(user_wdata), .user_rdata(user_rdata),
    .wr_ready(wr_ready), .rd_ready(rd_ready), .wr_error(wr_error), .rd_error(rd_error)
  );

  typedef struct {int id; logic [DW-1:0] rd; logic err;} exp_t;
  exp_t sbq[$];
  int glog[$];
  int checks = 0, errors = 0;
  bit stall = 1'b0;
  logic [DW-1:0] smem [16];
  logic [DW-1:0] mmem [16];

  function automatic logic [DW-1:0] pre(int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic int pick(logic [N-1:0] v, int last);
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // fake AXI-Lite master: slave memory of 16 words at 0..63, anything above errors
  initial begin
    logic s_we;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    bit s_err;
    for (int i = 0; i < 16; i++) smem[i] = pre(i);
    wr_ready = 0; rd_ready = 0; wr_error = 0; rd_error = 0; user_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if ((write || read) && !stall) begin
        s_we = write;
        s_a = write ? user_waddr : user_raddr;
        s_d = user_wdata;
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #2;
        s_err = s_a >= 64;
        if (s_we) begin
          if (!s_err) smem[s_a[5:2]] = s_d;
          wr_ready = 1; wr_error = s_err;
        end else begin
          user_rdata = s_err ? '0 : smem[s_a[5:2]];
          rd_ready = 1; rd_error = s_err;
        end
        @(posedge clk); #2;
        wr_ready = 0; rd_ready = 0; wr_error = 0; rd_error = 0;
      end
    end
  end

  // monitor: grants checked against the round-robin rule, responses popped from the scoreboard
  initial begin
    int last, g;
    logic w, err;
    logic [AW-1:0] a;
    logic [DW-1:0] d, rd;
    exp_t e;
    for (int i = 0; i < 16; i++) mmem[i] = pre(i);
    last = N - 1;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sbq.delete();
        last = N - 1;
      end else begin
        #1;
        if (req_ready != 0) begin
          g = pick(req_valid, last);
          chk("grant", 64'(req_ready), g < 0 ? 64'd0 : 64'(1 << g));
          if (g >= 0) begin
            w = req_we[g];
            a = req_addr[g*AW +: AW];
            d = req_wdata[g*DW +: DW];
            chk("wr_pulse", 64'(write), 64'(w));
            chk("rd_pulse", 64'(read), 64'(!w));
            chk("grant_id", 64'(grant_id), 64'(g));
            if (w) begin
              chk("waddr", 64'(user_waddr), 64'(a));
              chk("wdata", 64'(user_wdata), 64'(d));
            end else chk("raddr", 64'(user_raddr), 64'(a));
            err = a >= 64;
            rd = (!w && !err) ? mmem[a[5:2]] : '0;
            if (w && !err) mmem[a[5:2]] = d;
            sbq.push_back('{g, rd, err});
            glog.push_back(g);
            last = g;
          end
        end
        if (resp_valid != 0) begin
          if (sbq.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'd0);
          else begin
            e = sbq.pop_front();
            chk("resp_id", 64'(resp_valid), 64'(1 << e.id));
            chk("resp_rdata", 64'(resp_rdata), 64'(e.rd));
            chk("resp_err", 64'(resp_err), 64'(e.err));
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~req_ready;
  endtask

  task automatic post(int i, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic wait_quiet(int budget);
    int n = 0;
    while ((req_valid != 0 || busy || sbq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("quiet_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic check_zero();
    chk("z_busy", 64'(busy), 0);
    chk("z_stuck", 64'(stuck), 0);
    chk("z_write", 64'(write), 0);
    chk("z_read", 64'(read), 0);
    chk("z_req_ready", 64'(req_ready), 0);
    chk("z_resp_valid", 64'(resp_valid), 0);
    chk("z_grant_id", 64'(grant_id), 0);
    chk("z_waddr", 64'(user_waddr), 0);
    chk("z_raddr", 64'(user_raddr), 0);
    chk("z_wdata", 64'(user_wdata), 0);
    chk("z_rdata", 64'(resp_rdata), 0);
    chk("z_err", 64'(resp_err), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 0;
    req_valid = '0;
    #1 check_zero();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int base;
    logic [AW-1:0] a;
    #1 rst_n = 0;
    #1 check_zero();
    repeat (2) @(negedge clk);
    rst_n = 1;
    tick();
    post(1, 1, 32'h10, 32'hDEADBEEF);
    wait_quiet(100);
    post(2, 0, 32'h10, '0);
    wait_quiet(100);
    do_reset();
    tick();
    base = glog.size();
    for (int i = 0; i < N; i++) post(i, 0, 32'(4 * i), '0);
    wait_quiet(200);
    chk("rr_count", 64'(glog.size() - base), 64'd4);
    for (int k = 0; k < 4; k++) if (base + k < glog.size()) chk("rr_order", 64'(glog[base+k]), 64'(k));
    base = glog.size();
    for (int c = 0; c < 400 && glog.size() - base < 10; c++) begin
      tick();
      if (!req_valid[0]) post(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom);
      if (!req_valid[3]) post(3, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom);
    end
    wait_quiet(200);
    chk("fair_count", 64'(glog.size() - base >= 10), 64'd1);
    for (int k = 0; k < 10; k++) if (base + k < glog.size()) chk("fair_seq", 64'(glog[base+k]), (k % 2) ? 64'd3 : 64'd0);
    post(2, 1, 32'd200, $urandom);
    wait_quiet(100);
    post(2, 1, 32'h24, $urandom);
    wait_quiet(100);
    for (int c = 0; c < 300; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          a = ($urandom_range(0, 7) == 0) ? 32'(64 + $urandom_range(0, 200)) : 32'($urandom_range(0, 15) * 4);
          post(i, 1'($urandom_range(0, 1)), a, $urandom);
        end
    end
    wait_quiet(600);
    chk("no_stuck", 64'(stuck), 0);
    stall = 1;
    tick();
    post(1, 1, 32'h30, 32'h1234_5678);
    repeat (14) tick();
    chk("stuck_early", 64'(stuck), 0);
    chk("busy_wait", 64'(busy), 1);
    repeat (4) tick();
    chk("stuck_set", 64'(stuck), 1);
    chk("busy_stuck", 64'(busy), 1);
    repeat (10) tick();
    chk("stuck_hold", 64'(stuck), 1);
    do_reset();
    stall = 0;
    tick();
    base = glog.size();
    post(0, 0, 32'h4, '0);
    post(1, 0, 32'h8, '0);
    wait_quiet(100);
    chk("post_rst_count", 64'(glog.size() - base), 64'd2);
    if (glog.size() - base >= 2) begin
      chk("post_rst_first", 64'(glog[base]), 64'd0);
      chk("post_rst_second", 64'(glog[base+1]), 64'd1);
    end
    chk("sb_empty", 64'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
endmodule
